// File: rtl/sonar_pkg.sv
// Shared types and default constants for the sonar echo responder.
//   width_t      : 20-bit echo width / cycle counter type
//   state_e      : per-channel FSM state encoding
//   MIN_TRIG, ECHO_DELAY, MAX_ECHO, HOLDOFF : default timing parameters
//   clamp_width  : maps a programmed width onto the echo width actually produced
package sonar_pkg;

    localparam int unsigned WIDTH_W = 20;

    typedef logic [WIDTH_W-1:0] width_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_TRIG  = 3'd1,
        ST_DELAY = 3'd2,
        ST_ECHO  = 3'd3,
        ST_HOLD  = 3'd4
    } state_e;

    localparam int unsigned MIN_TRIG   = 20;
    localparam int unsigned ECHO_DELAY = 100;
    localparam width_t      MAX_ECHO   = 20'd882000;
    localparam int unsigned HOLDOFF    = 1000;

    // A zero or over-range programmed width means "no object": answer with max_w.
    function automatic width_t clamp_width(input width_t d, input width_t max_w);
        return ((d == '0) || (d > max_w)) ? max_w : d;
    endfunction

endpackage

// File: rtl/sonar_echo_channel.sv
// One sonar echo channel: trigger synchronizer, trigger-width qualification,
// fixed delay, programmable-width echo pulse and post-echo holdoff.
//   clk      : system clock, rising edge
//   reset    : asynchronous active-low reset
//   trig     : asynchronous trigger input
//   d        : programmed echo width in clk cycles (sampled when a trigger is accepted)
//   s        : registered echo pulse, high only while echoing
//   busy     : registered "channel not idle" flag
//   trig_err : registered one-cycle pulse when a trigger is rejected as too short
module sonar_echo_channel #(
    parameter int unsigned                  MIN_TRIG   = sonar_pkg::MIN_TRIG,
    parameter int unsigned                  ECHO_DELAY = sonar_pkg::ECHO_DELAY,
    parameter logic [sonar_pkg::WIDTH_W-1:0] MAX_ECHO  = sonar_pkg::MAX_ECHO,
    parameter int unsigned                  HOLDOFF    = sonar_pkg::HOLDOFF
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          trig,
    input  logic [sonar_pkg::WIDTH_W-1:0] d,
    output logic                          s,
    output logic                          busy,
    output logic                          trig_err
);
    import sonar_pkg::*;

    // Thresholds in counter width; timing parameters are expected to fit in 20 bits.
    localparam width_t MIN_W   = width_t'(MIN_TRIG);
    localparam width_t DELAY_W = width_t'(ECHO_DELAY);
    localparam width_t HOLD_W  = width_t'(HOLDOFF);
    localparam width_t ONE     = width_t'(1);
    localparam width_t CNT_SAT = '1;

    logic   sync1;
    logic   trig_s;
    state_e state;
    state_e state_nx;
    width_t cnt;
    width_t cnt_nx;
    width_t echo_w;
    width_t echo_w_nx;
    logic   err_nx;

    // Two-flop synchronizer for the asynchronous trigger.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1  <= 1'b0;
            trig_s <= 1'b0;
        end else begin
            sync1  <= trig;
            trig_s <= sync1;
        end
    end

    // Next-state logic. A single counter is reused: trigger width in TRIG,
    // elapsed cycles in DELAY / ECHO / HOLD (each phase restarts it at 1).
    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt;
        echo_w_nx = echo_w;
        err_nx    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (trig_s) begin
                    state_nx = ST_TRIG;
                    cnt_nx   = ONE;
                end
            end
            ST_TRIG: begin
                if (trig_s) begin
                    if (cnt != CNT_SAT) begin
                        cnt_nx = cnt + ONE;
                    end
                end else if (cnt >= MIN_W) begin
                    state_nx  = ST_DELAY;
                    cnt_nx    = ONE;
                    echo_w_nx = clamp_width(d, MAX_ECHO);
                end else begin
                    state_nx = ST_IDLE;
                    cnt_nx   = '0;
                    err_nx   = 1'b1;
                end
            end
            ST_DELAY: begin
                if (cnt >= DELAY_W) begin
                    state_nx = ST_ECHO;
                    cnt_nx   = ONE;
                end else begin
                    cnt_nx = cnt + ONE;
                end
            end
            ST_ECHO: begin
                if (cnt >= echo_w) begin
                    state_nx = ST_HOLD;
                    cnt_nx   = ONE;
                end else begin
                    cnt_nx = cnt + ONE;
                end
            end
            ST_HOLD: begin
                // Holdoff elapsed: leave only once the trigger line is released,
                // so a trigger held across holdoff is never treated as new.
                if (cnt >= HOLD_W) begin
                    if (!trig_s) begin
                        state_nx = ST_IDLE;
                        cnt_nx   = '0;
                    end
                end else begin
                    cnt_nx = cnt + ONE;
                end
            end
            default: begin
                state_nx = ST_IDLE;
                cnt_nx   = '0;
            end
        endcase
    end

    // State, counters and registered outputs (outputs decoded from next state).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            echo_w   <= '0;
            s        <= 1'b0;
            busy     <= 1'b0;
            trig_err <= 1'b0;
        end else begin
            state    <= state_nx;
            cnt      <= cnt_nx;
            echo_w   <= echo_w_nx;
            s        <= (state_nx == ST_ECHO);
            busy     <= (state_nx != ST_IDLE);
            trig_err <= err_nx;
        end
    end

endmodule

// File: rtl/sonar_responder.sv
// Three-channel sonar echo responder: each trigger input Tn is answered with an
// echo pulse Sn of programmed width Dn after a fixed delay; channels are independent.
//   clk            : system clock, rising edge
//   reset          : asynchronous active-low reset
//   T1, T2, T3     : trigger inputs
//   D1, D2, D3     : programmed echo widths (clk cycles)
//   S1, S2, S3     : registered echo outputs
//   busy[2:0]      : per-channel not-idle flags, bit 2 = channel 1 .. bit 0 = channel 3
//   trig_err[2:0]  : per-channel short-trigger reject pulses, same bit order
module sonar_responder #(
    parameter int unsigned                  MIN_TRIG   = sonar_pkg::MIN_TRIG,
    parameter int unsigned                  ECHO_DELAY = sonar_pkg::ECHO_DELAY,
    parameter logic [sonar_pkg::WIDTH_W-1:0] MAX_ECHO  = sonar_pkg::MAX_ECHO,
    parameter int unsigned                  HOLDOFF    = sonar_pkg::HOLDOFF
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          T1,
    input  logic                          T2,
    input  logic                          T3,
    input  logic [sonar_pkg::WIDTH_W-1:0] D1,
    input  logic [sonar_pkg::WIDTH_W-1:0] D2,
    input  logic [sonar_pkg::WIDTH_W-1:0] D3,
    output logic                          S1,
    output logic                          S2,
    output logic                          S3,
    output logic [2:0]                    busy,
    output logic [2:0]                    trig_err
);
    import sonar_pkg::*;

    // Channel 1
    sonar_echo_channel #(
        .MIN_TRIG   (MIN_TRIG),
        .ECHO_DELAY (ECHO_DELAY),
        .MAX_ECHO   (MAX_ECHO),
        .HOLDOFF    (HOLDOFF)
    ) u_ch1 (
        .clk      (clk),
        .reset    (reset),
        .trig     (T1),
        .d        (D1),
        .s        (S1),
        .busy     (busy[2]),
        .trig_err (trig_err[2])
    );

    // Channel 2
    sonar_echo_channel #(
        .MIN_TRIG   (MIN_TRIG),
        .ECHO_DELAY (ECHO_DELAY),
        .MAX_ECHO   (MAX_ECHO),
        .HOLDOFF    (HOLDOFF)
    ) u_ch2 (
        .clk      (clk),
        .reset    (reset),
        .trig     (T2),
        .d        (D2),
        .s        (S2),
        .busy     (busy[1]),
        .trig_err (trig_err[1])
    );

    // Channel 3
    sonar_echo_channel #(
        .MIN_TRIG   (MIN_TRIG),
        .ECHO_DELAY (ECHO_DELAY),
        .MAX_ECHO   (MAX_ECHO),
        .HOLDOFF    (HOLDOFF)
    ) u_ch3 (
        .clk      (clk),
        .reset    (reset),
        .trig     (T3),
        .d        (D3),
        .s        (S3),
        .busy     (busy[0]),
        .trig_err (trig_err[0])
    );

endmodule

// File: tb/tb_sonar_responder.sv
// Bench for sonar_responder: timestamp-based behavioural model checked every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_sonar_responder;

    localparam int unsigned MIN_T = 20;
    localparam int unsigned ED    = 100;
    localparam int unsigned HO    = 400;
    localparam logic [19:0] MAXE  = 20'd3000;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  t_vec = 3'b000;   // bit 2 = channel 1
    logic        T1, T2, T3;
    logic [19:0] D1, D2, D3;
    logic        S1, S2, S3;
    logic [2:0]  busy, trig_err;
    logic [2:0]  s_now;

    int n_tests = 0;
    int n_fail  = 0;

    assign T1 = t_vec[2];
    assign T2 = t_vec[1];
    assign T3 = t_vec[0];
    assign s_now = {S1, S2, S3};

    always #5 clk = ~clk;

    sonar_responder #(
        .MIN_TRIG   (MIN_T),
        .ECHO_DELAY (ED),
        .MAX_ECHO   (MAXE),
        .HOLDOFF    (HO)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .T1       (T1),
        .T2       (T2),
        .T3       (T3),
        .D1       (D1),
        .D2       (D2),
        .D3       (D3),
        .S1       (S1),
        .S2       (S2),
        .S3       (S3),
        .busy     (busy),
        .trig_err (trig_err)
    );

    // ---------------- behavioural model ----------------
    // Per channel: mode 0 = free, 1 = measuring trigger, 2 = serving an accepted
    // trigger described by absolute cycle stamps (echo rise, echo fall, holdoff end).
    int          cyc = 0;
    int          mode [3];
    int          len [3];
    int          rise_at [3];
    int          fall_at [3];
    int          hold_end [3];
    logic [2:0]  h1 = '0, h2 = '0;
    logic        ts_m;
    logic [19:0] d_arr [3];
    logic [2:0]  exp_s = '0, exp_busy = '0, exp_err = '0;

    always_comb begin
        d_arr[2] = D1;
        d_arr[1] = D2;
        d_arr[0] = D3;
    end

    function automatic int echo_len(input logic [19:0] d);
        if (d == 20'd0 || d > MAXE) return int'(MAXE);
        return int'(d);
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int b = 0; b < 3; b++) begin
                mode[b] = 0; len[b] = 0; rise_at[b] = 0; fall_at[b] = 0; hold_end[b] = 0;
            end
            h1 = '0; h2 = '0;
            exp_s = '0; exp_busy = '0; exp_err = '0;
        end else begin
            cyc = cyc + 1;
            for (int b = 0; b < 3; b++) begin
                ts_m  = h2[b];          // trigger as seen two sampling edges ago
                h2[b] = h1[b];
                h1[b] = t_vec[b];
                exp_err[b] = 1'b0;
                case (mode[b])
                    0: if (ts_m) begin mode[b] = 1; len[b] = 1; end
                    1: begin
                        if (ts_m) begin
                            if (len[b] < 1048575) len[b] = len[b] + 1;
                        end else if (len[b] >= int'(MIN_T)) begin
                            rise_at[b]  = cyc + int'(ED);
                            fall_at[b]  = rise_at[b] + echo_len(d_arr[b]);
                            hold_end[b] = fall_at[b] + int'(HO);
                            mode[b]     = 2;
                        end else begin
                            exp_err[b] = 1'b1;
                            mode[b]    = 0;
                        end
                    end
                    default: if (cyc >= hold_end[b] && !ts_m) mode[b] = 0;
                endcase
                exp_s[b]    = (mode[b] == 2) && (cyc >= rise_at[b]) && (cyc < fall_at[b]);
                exp_busy[b] = (mode[b] != 0);
            end
        end
    end

    // ---------------- checking ----------------
    task automatic chk3(input string name, input logic [2:0] act, input logic [2:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %b, expected %b", name, cyc, act, exp);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin
        chk3("S", s_now, exp_s);
        chk3("busy", busy, exp_busy);
        chk3("trig_err", trig_err, exp_err);
    end

    // Echo timing monitor used by the literal checks.
    int         last_rise [3];
    int         last_fall [3];
    int         rise_cnt [3];
    int         err_cnt [3];
    logic [2:0] s_prev = '0;

    always @(negedge clk) begin
        for (int b = 0; b < 3; b++) begin
            if (s_now[b] && !s_prev[b]) begin last_rise[b] = cyc; rise_cnt[b]++; end
            if (!s_now[b] && s_prev[b]) last_fall[b] = cyc;
            if (trig_err[b]) err_cnt[b]++;
        end
        s_prev = s_now;
    end

    task automatic clear_counts();
        for (int b = 0; b < 3; b++) begin rise_cnt[b] = 0; err_cnt[b] = 0; end
    endtask

    // Hold trigger bit b high for n sampled cycles; returns the edge that first samples it low.
    task automatic pulse(input int b, input int n, output int fall_edge);
        t_vec[b] = 1'b1;
        repeat (n) @(negedge clk);
        t_vec[b] = 1'b0;
        fall_edge = cyc + 1;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        repeat (4) @(negedge clk);
        while (busy != 3'b000 && n < budget) begin @(negedge clk); n++; end
        chk3("idle_within_budget", busy, 3'b000);
    endtask

    task automatic wait_s_high(input int b, input int budget);
        int n;
        n = 0;
        while (!s_now[b] && n < budget) begin @(negedge clk); n++; end
        chk_int("echo_started", int'(s_now[b]), 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "watchdog");
    end

    int fe, fe2;
    int hi_left [3];

    initial begin
        reset = 1'b0;
        D1 = 20'd0; D2 = 20'd0; D3 = 20'd0;
        for (int b = 0; b < 3; b++) begin last_rise[b] = 0; last_fall[b] = 0; hi_left[b] = 0; end
        clear_counts();
        repeat (3) @(negedge clk);
        chk3("reset_S", s_now, 3'b000);
        chk3("reset_busy", busy, 3'b000);
        chk3("reset_trig_err", trig_err, 3'b000);
        reset = 1'b1;
        repeat (5) @(negedge clk);

        // Valid trigger on channel 1: echo 102 edges after trigger low, width as programmed.
        D1 = 20'd500;
        pulse(2, 26, fe);
        wait_idle(5000);
        chk_int("ch1_rise_latency", last_rise[2] - fe, 102);
        chk_int("ch1_echo_width", last_fall[2] - last_rise[2], 500);
        chk_int("ch1_echo_count", rise_cnt[2], 1);

        // Short triggers on channel 2: 10 and 19 rejected, 20 accepted.
        clear_counts();
        D2 = 20'd50;
        pulse(1, 10, fe);
        wait_idle(100);
        chk_int("ch2_err_10", err_cnt[1], 1);
        chk_int("ch2_no_echo_10", rise_cnt[1], 0);
        pulse(1, 19, fe);
        wait_idle(100);
        chk_int("ch2_err_19", err_cnt[1], 2);
        pulse(1, 20, fe);
        wait_idle(2000);
        chk_int("ch2_err_20", err_cnt[1], 2);
        chk_int("ch2_echo_20", rise_cnt[1], 1);
        chk_int("ch2_width_20", last_fall[1] - last_rise[1], 50);

        // Channel 3: zero and over-range widths give MAX_ECHO; later D changes ignored.
        D3 = 20'd0;
        pulse(0, 25, fe);
        repeat (5) @(negedge clk);
        D3 = 20'd123;
        wait_idle(6000);
        chk_int("ch3_width_zero", last_fall[0] - last_rise[0], 3000);
        D3 = 20'd4000;
        pulse(0, 25, fe);
        repeat (5) @(negedge clk);
        D3 = 20'd7;
        wait_idle(6000);
        chk_int("ch3_width_over", last_fall[0] - last_rise[0], 3000);

        // Retriggers during echo and holdoff are ignored; a later trigger works.
        clear_counts();
        D1 = 20'd300;
        pulse(2, 25, fe);
        wait_s_high(2, 200);
        repeat (50) @(negedge clk);
        pulse(2, 25, fe2);
        while (s_now[2] && cyc < fe + 2000) @(negedge clk);
        repeat (100) @(negedge clk);
        pulse(2, 30, fe2);
        wait_idle(2000);
        chk_int("ch1_single_echo", rise_cnt[2], 1);
        chk_int("ch1_single_width", last_fall[2] - last_rise[2], 300);
        pulse(2, 25, fe);
        wait_idle(2000);
        chk_int("ch1_new_echo", rise_cnt[2], 2);
        chk_int("ch1_new_latency", last_rise[2] - fe, 102);

        // Three simultaneous triggers, concurrent echoes.
        D1 = 20'd100; D2 = 20'd200; D3 = 20'd300;
        t_vec = 3'b111;
        repeat (25) @(negedge clk);
        t_vec = 3'b000;
        fe = cyc + 1;
        wait_idle(2000);
        chk_int("conc_w1", last_fall[2] - last_rise[2], 100);
        chk_int("conc_w2", last_fall[1] - last_rise[1], 200);
        chk_int("conc_w3", last_fall[0] - last_rise[0], 300);
        chk_int("conc_rise_ch1", last_rise[2] - fe, 102);
        chk_int("conc_rise_ch3", last_rise[0] - fe, 102);

        // Reset 50 cycles into an echo drops S immediately; no echo afterwards.
        D2 = 20'd1000;
        pulse(1, 25, fe);
        wait_s_high(1, 200);
        repeat (50) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        chk3("reset_drop_S", s_now, 3'b000);
        chk3("reset_drop_busy", busy, 3'b000);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        clear_counts();
        repeat (2000) @(negedge clk);
        chk_int("post_reset_no_echo", rise_cnt[1], 0);
        chk3("post_reset_idle", busy, 3'b000);

        // Random independent traffic on all channels.
        for (int i = 0; i < 15000; i++) begin
            @(negedge clk);
            for (int b = 0; b < 3; b++) begin
                if (hi_left[b] > 0) begin
                    t_vec[b] = 1'b1;
                    hi_left[b]--;
                end else begin
                    t_vec[b] = 1'b0;
                    if ($urandom_range(0, 149) == 0) begin
                        hi_left[b] = int'($urandom_range(1, 40));
                        case ($urandom_range(0, 7))
                            0:       d_arr_set(b, 20'd0);
                            1:       d_arr_set(b, 20'($urandom_range(3001, 1048575)));
                            default: d_arr_set(b, 20'($urandom_range(1, 400)));
                        endcase
                    end else if ($urandom_range(0, 49) == 0) begin
                        d_arr_set(b, 20'($urandom_range(0, 3100)));
                    end
                end
            end
        end
        t_vec = 3'b000;
        wait_idle(6000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    task automatic d_arr_set(input int b, input logic [19:0] v);
        case (b)
            2:       D1 = v;
            1:       D2 = v;
            default: D3 = v;
        endcase
    endtask

endmodule

// File: doc/sonar_responder.md
SONAR_RESPONDER -- requirements
Module: sonar_responder

Interface
REQ-001 Parameter MIN_TRIG, default 20: minimum trigger high time in clk cycles for a trigger to be accepted.
REQ-002 Parameter ECHO_DELAY, default 100: cycles from accepted trigger end to echo rise.
REQ-003 Parameter MAX_ECHO, default 20'd882000: echo width used for no-object or over-range distances.
REQ-004 Parameter HOLDOFF, default 1000: cycles after echo fall during which triggers are ignored.
REQ-005 clk  input  1  single system clock; all logic on its rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset.
REQ-007 T1, T2, T3  input  1 each  trigger pulses from the sonar controller.
REQ-008 D1, D2, D3  input  20 each  programmed echo width in clk cycles per channel.
REQ-009 S1, S2, S3  output  1 each  echo pulses back to the sonar controller.
REQ-010 busy  output  3  per-channel not-IDLE flag; bit 2 = channel 1, bit 0 = channel 3.
REQ-011 trig_err  output  3  per-channel one-cycle pulse on a rejected short trigger; same bit order as busy.

Function
REQ-012 Each channel SHALL pass Tn through a 2-flop synchronizer; trig_s denotes the second flop's output.
REQ-013 Each channel SHALL run an FSM with states IDLE, TRIG, DELAY, ECHO, HOLD.
REQ-014 IDLE: trig_s=1 -> TRIG with the width counter set to 1.
REQ-015 TRIG: trig_s=1 -> width counter increments, saturating at 20 bits.
REQ-016 TRIG: trig_s=0 with width >= MIN_TRIG -> DELAY, latching Dn into a 20-bit width register on that edge.
REQ-017 TRIG: trig_s=0 with width < MIN_TRIG -> IDLE, with trig_err pulsed high for exactly one cycle.
REQ-018 Latched width SHALL be MAX_ECHO if Dn==0 or Dn>MAX_ECHO, else Dn.
REQ-019 DELAY SHALL last exactly ECHO_DELAY cycles, then -> ECHO with Sn registered high.
REQ-020 Sn rise latency: the (ECHO_DELAY+2)th rising edge after the edge at which Tn is first sampled low.
REQ-021 ECHO: Sn SHALL stay high for exactly the latched width in cycles, then fall and -> HOLD.
REQ-022 HOLD SHALL last HOLDOFF cycles, then -> IDLE only when trig_s=0; otherwise remain in HOLD.
REQ-023 Trigger activity in DELAY, ECHO or HOLD SHALL be ignored; Dn changes after latching SHALL have no effect.
REQ-024 Channels SHALL be fully independent; simultaneous triggers on all three channels SHALL be served concurrently.
REQ-025 Sn and busy SHALL be registered outputs; Sn SHALL be high only in ECHO.

Reset
REQ-026 reset=0 SHALL immediately force all FSMs to IDLE, clear all counters, synchronizers and latched widths, and drive S1-S3=0, busy=0, trig_err=0.
REQ-027 Reset asserted mid-ECHO SHALL drop Sn asynchronously; after release, no echo SHALL occur without a new valid trigger.

Structure
REQ-028 Package sonar_pkg SHALL hold the FSM state enum, the 20-bit width typedef, and default constants MIN_TRIG, ECHO_DELAY, MAX_ECHO and HOLDOFF.
REQ-029 Sub-module sonar_echo_channel (synchronizer, FSM, counters for one channel) SHALL be instanced three times in sonar_responder.

Verification
REQ-030 T1 high 26 cycles, D1=5000 -> S1 rises 102 cycles after T1 falls and stays high exactly 5000 cycles; busy[2] high throughout.
REQ-031 T2 high 10 cycles -> trig_err[1] high for 1 cycle, S2 stays 0, busy[1] returns to 0.
REQ-032 D3=0, then D3=900000, each with a valid trigger -> S3 width 882000 cycles in both cases.
REQ-033 Second T1 pulse during ECHO and another within HOLD -> both ignored, exactly one echo produced; after HOLD elapses, a new trigger yields a new echo.
REQ-034 All three triggers valid on the same cycle with D=100/200/300 -> three concurrent echoes of exactly those widths.
REQ-035 reset=0 asserted 50 cycles into an echo -> Sn low immediately; after release, S stays low for 2000 cycles with no trigger applied.
